// File: rtl/float_mul_stall_adapter.sv
// rtl/float_mul_stall_adapter.sv - stall-honouring wrapper around the fixed-latency float multiplier
// Holds a single-precision multiply core plus the valid tracker and credit-guarded result FIFO.
`timescale 1ns/1ps

module float_dspmul #(
  parameter int LATENCY = 4
) (
  input  logic        clock,
  input  logic        areset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q
);

  logic              sign;
  logic [7:0]        ea, eb;
  logic [22:0]       fa, fb;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0]       prod;
  logic signed [9:0] exp_s, exp_n;
  logic [22:0]       mant;
  logic              guard, sticky, round_up;
  logic [23:0]       mant_r;
  logic [31:0]       p_comb;
  logic [31:0]       pipe [LATENCY];

  // Denormal inputs and results flush to signed zero; rounding is nearest-even.
  always_comb begin
    sign   = a[31] ^ b[31];
    ea     = a[30:23];
    eb     = b[30:23];
    fa     = a[22:0];
    fb     = b[22:0];
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_inf  = (ea == 8'hFF) && (fa == 23'h0);
    b_inf  = (eb == 8'hFF) && (fb == 23'h0);
    a_nan  = (ea == 8'hFF) && (fa != 23'h0);
    b_nan  = (eb == 8'hFF) && (fb != 23'h0);
    prod   = 48'({1'b1, fa}) * 48'({1'b1, fb});
    exp_s  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_n  = exp_s + 10'sd1;
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
      exp_n  = exp_s;
    end
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {23'h0, round_up};
    if (mant_r[23]) exp_n = exp_n + 10'sd1;

    p_comb = {sign, exp_n[7:0], mant_r[22:0]};
    if (exp_n >= 10'sd255)    p_comb = {sign, 8'hFF, 23'h0};
    else if (exp_n <= 10'sd0) p_comb = {sign, 31'h0};

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      p_comb = 32'h7FC0_0000;
    else if (a_inf || b_inf)
      p_comb = {sign, 8'hFF, 23'h0};
    else if (a_zero || b_zero)
      p_comb = {sign, 31'h0};
  end

  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      for (int k = 0; k < LATENCY; k++) pipe[k] <= 32'h0;
    end else begin
      pipe[0] <= p_comb;
      for (int k = 1; k < LATENCY; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign q = pipe[LATENCY-1];

endmodule

module float_mul_stall_adapter #(
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ivalid,
  output logic        oready,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        ovalid,
  input  logic        iready,
  output logic [31:0] result
);

  localparam int CW = $clog2(LATENCY + FIFO_DEPTH + 1);

  logic [LATENCY-1:0] vld_sr;
  logic [31:0]        core_q;
  logic [31:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]  wr_ptr, rd_ptr;
  logic [ADDR_W:0]    fifo_count;
  logic [CW-1:0]      inflight, credit_used;
  logic               accept, push, pop;

  float_dspmul #(.LATENCY(LATENCY)) u_core (
    .clock  (clock),
    .areset (~resetn),
    .a      (in1),
    .b      (in2),
    .q      (core_q)
  );

  // Every beat in the core pipeline already owns a FIFO slot, so pushes never overflow.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < LATENCY; k++) inflight = inflight + CW'(vld_sr[k]);
    credit_used = inflight + CW'(fifo_count);
  end

  assign oready = (credit_used < CW'(FIFO_DEPTH));
  assign accept = ivalid & oready;
  assign push   = vld_sr[LATENCY-1];
  assign ovalid = (fifo_count != '0);
  assign pop    = ovalid & iready;
  assign result = ovalid ? mem[rd_ptr] : 32'h0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_sr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      vld_sr[0] <= accept;
      for (int k = 1; k < LATENCY; k++) vld_sr[k] <= vld_sr[k-1];
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= core_q;
  end

endmodule

// File: tb/tb_float_mul_stall_adapter.sv
// tb/tb_float_mul_stall_adapter.sv - randomized self-checking bench for float_mul_stall_adapter
`timescale 1ns/1ps

module tb_float_mul_stall_adapter;

  localparam int LAT   = 4;
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        ivalid = 1'b0;
  logic        iready = 1'b0;
  logic [31:0] in1 = 32'h0;
  logic [31:0] in2 = 32'h0;
  logic        oready, ovalid;
  logic [31:0] result;

  always #5 clock = ~clock;

  float_mul_stall_adapter #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .ADDR_W(3)) dut (
    .clock  (clock),
    .resetn (resetn),
    .ivalid (ivalid),
    .oready (oready),
    .in1    (in1),
    .in2    (in2),
    .ovalid (ovalid),
    .iready (iready),
    .result (result)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] exp_q[$];
  int          rdy_q[$];

  logic        obs_oready, obs_ovalid;
  logic [31:0] obs_result;
  bit          m_acc, m_pop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic real sp2real(input logic [31:0] a);
    logic [10:0] e;
    if (a[30:23] == 8'h00) return $bitstoreal({a[31], 63'h0});
    e = 11'(a[30:23]) + 11'd896;
    return $bitstoreal({a[31], e, a[22:0], 29'h0});
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:52] == 11'h0) return {d[63], 31'h0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Operands carry 12 significant bits, so the exact product fits a single significand.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return real2sp(sp2real(a) * sp2real(b));
  endfunction

  function automatic logic [31:0] rand_op();
    if ($urandom_range(0, 9) == 0) return {1'($urandom_range(0, 1)), 31'h0};
    return {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 11'($urandom), 12'h0};
  endfunction

  task automatic step(input bit iv, input bit ir, input logic [31:0] a, input logic [31:0] b,
                      input string tag);
    bit exp_or, exp_ov;
    ivalid = iv;
    iready = ir;
    in1    = a;
    in2    = b;
    exp_or = exp_q.size() < DEPTH;
    exp_ov = (exp_q.size() > 0) && (rdy_q[0] <= cyc);
    obs_oready = oready;
    obs_ovalid = ovalid;
    obs_result = result;
    chk({tag, ".oready"}, 32'(oready), 32'(exp_or));
    chk({tag, ".ovalid"}, 32'(ovalid), 32'(exp_ov));
    chk({tag, ".result"}, result, exp_ov ? exp_q[0] : 32'h0);
    chk({tag, ".credit"}, 32'((32'($countones(dut.vld_sr)) + 32'(dut.fifo_count)) <= DEPTH), 32'd1);
    m_acc = iv && exp_or;
    m_pop = exp_ov && ir;
    if (m_pop) begin
      void'(exp_q.pop_front());
      void'(rdy_q.pop_front());
    end
    if (m_acc) begin
      exp_q.push_back(ref_mul(a, b));
      rdy_q.push_back(cyc + LAT + 1);
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    int pops, first_pop, last_pop, stalls, dut_acc, acc, guard;

    #2;
    chk("reset.ovalid", 32'(ovalid), 32'd0);
    chk("reset.oready", 32'(oready), 32'd1);
    chk("reset.result", result, 32'h0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    cyc = 0;

    step(1'b1, 1'b1, 32'h4000_0000, 32'h4040_0000, "single");
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b1, 32'h0, 32'h0, "single_wait");
      chk($sformatf("single.ovalid_c%0d", i), 32'(obs_ovalid), 32'(i == 5));
      if (i == 5) chk("single.product", obs_result, 32'h40C0_0000);
    end

    pops = 0; first_pop = -1; last_pop = -1; stalls = 0;
    for (int i = 0; i < 24; i++) begin
      if (i < 16) step(1'b1, 1'b1, rand_op(), 32'h3F80_0000, "stream");
      else        step(1'b0, 1'b1, 32'h0, 32'h0, "stream");
      if (i < 16 && !obs_oready) stalls++;
      if (obs_ovalid) begin
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
    chk("stream.stalls", 32'(stalls), 32'd0);
    chk("stream.pops", 32'(pops), 32'd16);
    chk("stream.span", 32'(last_pop - first_pop), 32'd15);

    dut_acc = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 1'b0, rand_op(), rand_op(), "bp_fill");
      if (obs_oready) dut_acc++;
    end
    chk("bp.accepts", 32'(dut_acc), 32'd8);
    chk("bp.oready_low", 32'(obs_oready), 32'd0);
    chk("bp.ovalid_held", 32'(obs_ovalid), 32'd1);
    pops = 0;
    for (int j = 0; j < 12; j++) begin
      step(1'b0, 1'b1, 32'h0, 32'h0, "bp_drain");
      if (j == 0) chk("bp.oready_at_first_pop", 32'(obs_oready), 32'd0);
      if (j == 1) chk("bp.oready_after_pop", 32'(obs_oready), 32'd1);
      if (obs_ovalid) pops++;
    end
    chk("bp.drained", 32'(pops), 32'd8);

    acc = 0; guard = 0;
    while (acc < 200 && guard < 3000) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_op(), rand_op(), "rand");
      if (m_acc) acc++;
      guard++;
    end
    chk("rand.accepted", 32'(acc), 32'd200);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(1'b0, 1'b1, 32'h0, 32'h0, "rand_drain");
    chk("rand.idle_ovalid", 32'(ovalid), 32'd0);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, rand_op(), rand_op(), "rst_fill");
    step(1'b0, 1'b0, 32'h0, 32'h0, "rst_fill");
    chk("rst.fifo_before", 32'(ovalid), 32'd1);
    ivalid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("rst.async_ovalid", 32'(ovalid), 32'd0);
    chk("rst.async_oready", 32'(oready), 32'd1);
    chk("rst.async_result", result, 32'h0);
    exp_q.delete();
    rdy_q.delete();
    @(posedge clock);
    #1;
    cyc++;
    resetn = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      step(1'b0, 1'b1, 32'h0, 32'h0, "rst_quiet");
      chk("rst.no_ovalid", 32'(obs_ovalid), 32'd0);
    end
    pops = 0;
    step(1'b1, 1'b1, 32'h3FC0_0000, 32'hC080_0000, "rst_next");
    for (int i = 0; i < LAT + 3; i++) begin
      step(1'b0, 1'b1, 32'h0, 32'h0, "rst_next_wait");
      if (obs_ovalid) begin
        pops++;
        chk("rst.next_product", obs_result, 32'hC0C0_0000);
      end
    end
    chk("rst.next_pops", 32'(pops), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
